// File: rtl/rv32i_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, control FSM states
// and the mux/ALU select encodings used by control, extend unit and datapath.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/rv32i_imm_decode.sv
// Opcode to immediate-type select for the extend unit; shared with the
// single-cycle decoder.
module rv32i_imm_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core, with a memory ready handshake
// and a watchdog that halts the core with a sticky BusError on a stuck request.
module rv32i_multicycle_control
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic       BusError
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          waiting, timed_out;

  assign waiting   = MemReq & ~MemReady;
  // The limit is judged on the registered count, so a ready in that cycle still wins.
  assign timed_out = (TIMEOUT_CYCLES != 0) && waiting && (wait_cnt == CW'(TIMEOUT_CYCLES));

  rv32i_imm_decode u_imm_decode (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_RESET;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || MemReady) wait_cnt <= '0;
      else if (waiting)                      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    Illegal    = 1'b0;
    BusError   = 1'b0;
    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECUTER;
          OP_I:              next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default: begin
            Illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      // Link value OldPC+4 is formed here and written back in ALUWB.
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_SUB;
        PCWrite    = Zero;
        next_state = S_FETCH;
      end
      S_HALT: BusError = 1'b1;
      default: next_state = S_RESET;
    endcase
    if (timed_out) next_state = S_HALT;
  end

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Self-checking bench for the multi-cycle control FSM: directed scenarios plus a
// randomized instruction stream checked against a per-instruction cycle model.
module tb_rv32i_multicycle_control;

  localparam int TMO = 4;

  logic       clk, rstn, Zero, MemReady;
  logic [6:0] op;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal, BusError;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [15:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [6:0]  op;
    logic        rdy;
    logic        z;
    logic [15:0] v;
  } step_t;

  step_t plan[$];

  rv32i_multicycle_control #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .op(op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .Illegal(Illegal), .BusError(BusError)
  );

  assign dut_vec = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, BusError};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic mr, mw, adr, irw, pcw, rw,
                                     input logic [1:0] rs, sa, sb, ao,
                                     input logic ill, be);
    return {mr, mw, adr, irw, pcw, rw, rs, sa, sb, ao, ill, be};
  endfunction

  function automatic logic [1:0] imm_model(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit supported(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // Expected control word for each phase of an instruction, straight from the state table.
  function automatic logic [15:0] fetch_vec(input logic rdy);
    return mk(1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
  endfunction

  task automatic push(input logic [6:0] o, input logic rdy, input logic z, input logic [15:0] v);
    step_t s;
    s.op = o; s.rdy = rdy; s.z = z; s.v = v;
    plan.push_back(s);
  endtask

  task automatic build_instr(input logic [6:0] o, input int fw, input int mw, input logic z);
    logic [15:0] mr_v, mw_v, dec_v;
    mr_v  = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    mw_v  = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    dec_v = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, !supported(o), 0);
    for (int i = 0; i < fw; i++) push(o, 1'b0, 1'($urandom), fetch_vec(1'b0));
    push(o, 1'b1, 1'($urandom), fetch_vec(1'b1));
    push(o, 1'($urandom), 1'($urandom), dec_v);
    case (o)
      7'b0110011: begin
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
      end
      7'b0010011: begin
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0));
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
      end
      7'b0000011: begin
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'($urandom), mr_v);
        push(o, 1'b1, 1'($urandom), mr_v);
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0));
      end
      7'b0100011: begin
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
        for (int i = 0; i < mw; i++) push(o, 1'b0, 1'($urandom), mw_v);
        push(o, 1'b1, 1'($urandom), mw_v);
      end
      7'b1100011:
        push(o, 1'($urandom), z, mk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0));
      7'b1101111: begin
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0));
        push(o, 1'($urandom), 1'($urandom), mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; op = 7'b0110011; MemReady = 1'b1; Zero = 1'b0;
    #3;
    vectors++;
    if (dut_vec !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %h expected %h", dut_vec, 16'h0000);
    end
    tick(); tick();
    release_reset();
    @(negedge clk);
    vectors++;
    if (dut_vec !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_state_cycle: got %h expected %h", dut_vec, 16'h0000);
    end
    tick();
  endtask

  task automatic test_directed_mix();
    plan.delete();
    build_instr(7'b0110011, 0, 0, 1'b0);
    build_instr(7'b0000011, 0, 3, 1'b0);
    build_instr(7'b1100011, 0, 0, 1'b1);
    build_instr(7'b1100011, 0, 0, 1'b0);
    build_instr(7'b0110111, 0, 0, 1'b0);
    build_instr(7'b0100011, 2, 1, 1'b0);
    build_instr(7'b1101111, 0, 0, 1'b0);
    build_instr(7'b0010011, TMO, 0, 1'b0);
    build_instr(7'b0000011, 1, TMO, 1'b0);
    foreach (plan[i]) begin
      op = plan[i].op; MemReady = plan[i].rdy; Zero = plan[i].z;
      @(negedge clk);
      vectors++;
      if (dut_vec !== plan[i].v || ImmSrc !== imm_model(plan[i].op)) begin
        miscompares++;
        $display("[TB] FAIL directed step %0d op=%b: got %h/imm %b expected %h/imm %b",
                 i, plan[i].op, dut_vec, ImmSrc, plan[i].v, imm_model(plan[i].op));
      end
      tick();
    end
  endtask

  task automatic test_random_program();
    logic [6:0] o;
    logic [6:0] ops [8];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0010111, 7'b1100111};
    plan.delete();
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 7'($urandom); while (supported(o));
      end else begin
        o = ops[$urandom_range(0, 7)];
      end
      build_instr(o, $urandom_range(0, TMO), $urandom_range(0, TMO), 1'($urandom));
    end
    foreach (plan[i]) begin
      op = plan[i].op; MemReady = plan[i].rdy; Zero = plan[i].z;
      @(negedge clk);
      vectors++;
      if (dut_vec !== plan[i].v || ImmSrc !== imm_model(plan[i].op)) begin
        miscompares++;
        $display("[TB] FAIL random step %0d op=%b: got %h/imm %b expected %h/imm %b",
                 i, plan[i].op, dut_vec, ImmSrc, plan[i].v, imm_model(plan[i].op));
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [15:0] halt_v;
    halt_v = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
    op = 7'b0110011; MemReady = 1'b0;
    // Counter reaches the limit after TMO waits; one more waiting cycle trips HALT.
    for (int i = 0; i <= TMO; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== fetch_vec(1'b0)) begin
        miscompares++;
        $display("[TB] FAIL timeout_wait %0d: got %h expected %h", i, dut_vec, fetch_vec(1'b0));
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      MemReady = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (dut_vec !== halt_v) begin
        miscompares++;
        $display("[TB] FAIL halt_sticky %0d: got %h expected %h", i, dut_vec, halt_v);
      end
      tick();
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (BusError !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL buserror_clear: got %b expected 0", BusError);
    end
    release_reset();
    MemReady = 1'b1;
    @(negedge clk);
    vectors++;
    if (dut_vec !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL timeout_reset_cycle: got %h expected %h", dut_vec, 16'h0000);
    end
    tick();
  endtask

  task automatic test_reset_mid_store();
    plan.delete();
    build_instr(7'b0100011, 0, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      op = plan[i].op; MemReady = plan[i].rdy; Zero = plan[i].z;
      @(negedge clk);
      vectors++;
      if (dut_vec !== plan[i].v) begin
        miscompares++;
        $display("[TB] FAIL store_pre_reset %0d: got %h expected %h", i, dut_vec, plan[i].v);
      end
      if (i < 4) tick();
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (MemReq !== 1'b0 || MemWrite !== 1'b0 || dut_vec !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL store_async_reset: got %h expected %h", dut_vec, 16'h0000);
    end
    release_reset();
    MemReady = 1'b0;
    @(negedge clk);
    vectors++;
    if (dut_vec !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL store_reset_cycle: got %h expected %h", dut_vec, 16'h0000);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (dut_vec !== fetch_vec(1'b0)) begin
      miscompares++;
      $display("[TB] FAIL fetch_after_reset: got %h expected %h", dut_vec, fetch_vec(1'b0));
    end
  endtask

  initial begin
    rstn = 1'b0; op = '0; MemReady = 1'b0; Zero = 1'b0;
    test_reset();
    test_directed_mix();
    test_random_program();
    test_timeout();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
